// File: rtl/complex_beam_combiner.sv
// complex_beam_combiner: channel-serial complex weight-and-sum for the beamformer datapath.
// Products -> add/sub -> accumulate -> round/shift/saturate; output backpressure freezes every stage.
module complex_beam_combiner #(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_CH      = 8,
   parameter int CH_W        = 3,
   parameter int ACC_WIDTH   = 40,
   parameter int OUT_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          coeff_we,
   input  logic [CH_W-1:0]               coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_re_wr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_im_wr,
   input  logic                          conj_en,
   input  logic [5:0]                    out_shift,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_WIDTH-1:0]  i_in,
   input  logic signed [DATA_WIDTH-1:0]  q_in,
   output logic [CH_W-1:0]               in_ch,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [OUT_WIDTH-1:0]   real_out,
   output logic signed [OUT_WIDTH-1:0]   imag_out,
   output logic                          sat_flag
);
   localparam int PW = DATA_WIDTH + COEFF_WIDTH;
   // Wide enough that the rounding constant for any 6-bit shift cannot overflow.
   localparam int RW = ACC_WIDTH + 66;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic signed [RW-1:0] OMAX =
      signed'({{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [RW-1:0] OMIN =
      signed'({{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

   logic signed [COEFF_WIDTH-1:0] w_re [NUM_CH];
   logic signed [COEFF_WIDTH-1:0] w_im [NUM_CH];

   logic                 en;
   logic                 accept;
   logic                 s1_valid;
   logic                 s1_conj;
   logic [CH_W-1:0]      s1_ch;
   logic signed [PW-1:0] p_ir, p_qi, p_qr, p_ii;
   logic                 s2_valid;
   logic [CH_W-1:0]      s2_ch;
   logic [PW:0]          s2_re, s2_im;
   logic                 s3_done;
   logic [ACC_WIDTH-1:0] acc_re, acc_im;
   logic [ACC_WIDTH-1:0] ext_re, ext_im;
   logic [OUT_WIDTH:0]   rs_re, rs_im;

   function automatic logic [OUT_WIDTH:0] round_sat(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [5:0]           sh);
      logic signed [RW-1:0] x;
      logic signed [RW-1:0] rnd;
      x   = signed'({{(RW-ACC_WIDTH){a[ACC_WIDTH-1]}}, a});
      rnd = '0;
      if (sh != 6'd0) rnd[sh - 6'd1] = 1'b1;
      x = (x + rnd) >>> sh;
      if (x > OMAX) return {1'b1, OMAX[OUT_WIDTH-1:0]};
      if (x < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
      return {1'b0, x[OUT_WIDTH-1:0]};
   endfunction

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;
   assign accept   = in_valid && en;
   assign ext_re   = {{(ACC_WIDTH-PW-1){s2_re[PW]}}, s2_re};
   assign ext_im   = {{(ACC_WIDTH-PW-1){s2_im[PW]}}, s2_im};
   assign rs_re    = round_sat(acc_re, out_shift);
   assign rs_im    = round_sat(acc_im, out_shift);

   // Weight bank survives rst; a same-edge write is invisible to the sample read this cycle.
   always_ff @(posedge clk) begin
      if (coeff_we) begin
         w_re[coeff_addr] <= coeff_re_wr;
         w_im[coeff_addr] <= coeff_im_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ch     <= '0;
         s1_valid  <= 1'b0;
         s1_conj   <= 1'b0;
         s1_ch     <= '0;
         p_ir      <= '0;
         p_qi      <= '0;
         p_qr      <= '0;
         p_ii      <= '0;
         s2_valid  <= 1'b0;
         s2_ch     <= '0;
         s2_re     <= '0;
         s2_im     <= '0;
         s3_done   <= 1'b0;
         acc_re    <= '0;
         acc_im    <= '0;
         out_valid <= 1'b0;
         real_out  <= '0;
         imag_out  <= '0;
         sat_flag  <= 1'b0;
      end else if (en) begin
         if (accept) in_ch <= (in_ch == LAST_CH) ? '0 : in_ch + 1'b1;

         s1_valid <= accept;
         s1_conj  <= conj_en;
         s1_ch    <= in_ch;
         p_ir     <= PW'(i_in) * PW'(w_re[in_ch]);
         p_qi     <= PW'(q_in) * PW'(w_im[in_ch]);
         p_qr     <= PW'(q_in) * PW'(w_re[in_ch]);
         p_ii     <= PW'(i_in) * PW'(w_im[in_ch]);

         s2_valid <= s1_valid;
         s2_ch    <= s1_ch;
         s2_re    <= s1_conj ? ({p_ir[PW-1], p_ir} + {p_qi[PW-1], p_qi})
                             : ({p_ir[PW-1], p_ir} - {p_qi[PW-1], p_qi});
         s2_im    <= s1_conj ? ({p_qr[PW-1], p_qr} - {p_ii[PW-1], p_ii})
                             : ({p_qr[PW-1], p_qr} + {p_ii[PW-1], p_ii});

         s3_done <= s2_valid && (s2_ch == LAST_CH);
         if (s2_valid) begin
            acc_re <= (s2_ch == '0) ? ext_re : acc_re + ext_re;
            acc_im <= (s2_ch == '0) ? ext_im : acc_im + ext_im;
         end

         out_valid <= s3_done;
         if (s3_done) begin
            real_out <= rs_re[OUT_WIDTH-1:0];
            imag_out <= rs_im[OUT_WIDTH-1:0];
            sat_flag <= rs_re[OUT_WIDTH] | rs_im[OUT_WIDTH];
         end
      end
   end
endmodule
